// File: rtl/isqrt_arbiter_pkg.sv
// Shared types for the isqrt arbiter: FSM state encoding and a width helper.
package isqrt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Used to size the core's step counter as clog2(RW+1).
  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/isqrt_arbiter_if.sv
// Request/response bundle between two requesters and the shared isqrt engine.
// rsp_rem exists only when ISQRT_REMAINDER_EN is defined.
interface isqrt_arbiter_if #(
  parameter int DW = 14
);
  localparam int RW = DW / 2;

  logic [1:0]    req_valid;
  logic [DW-1:0] req_data0;
  logic [DW-1:0] req_data1;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [RW-1:0] rsp_root;
`ifdef ISQRT_REMAINDER_EN
  logic [RW:0]   rsp_rem;
`endif
  logic          busy;

  modport master (
    output req_valid, req_data0, req_data1, rsp_ready,
    input  req_ready, rsp_valid, rsp_root, busy
`ifdef ISQRT_REMAINDER_EN
    , input rsp_rem
`endif
  );

  modport slave (
    input  req_valid, req_data0, req_data1, rsp_ready,
    output req_ready, rsp_valid, rsp_root, busy
`ifdef ISQRT_REMAINDER_EN
    , output rsp_rem
`endif
  );

endinterface

// File: rtl/isqrt_arbiter_core.sv
// Bit-serial restoring integer square root: one root bit per cycle, MSB first, DW/2 cycles.
// rem_o is exported only with ISQRT_REMAINDER_EN; the remainder register is always live.
module isqrt_arbiter_core
  import isqrt_arbiter_pkg::*;
#(
  parameter int DW = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [DW-1:0]   operand_i,
  output logic            last_o,
  output logic [DW/2-1:0] root_o
`ifdef ISQRT_REMAINDER_EN
  , output logic [DW/2:0] rem_o
`endif
);
  localparam int RW = DW / 2;
  localparam int CW = clog2(RW + 1);

  logic [DW-1:0] rad_q, rad_d;
  logic [RW:0]   rem_q, rem_d;
  logic [RW-1:0] root_q, root_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [RW+2:0] ext;
  logic [RW+2:0] trial;
  logic          trial_neg;
  logic          trial_pad_unused;
  logic [RW:0]   trial_rem;
  logic [RW:0]   root_sh;

  // A non-negative trial is bounded by 2*root, so its bit RW+1 is always zero.
  assign ext   = {rem_q, rad_q[DW-1 -: 2]};
  assign trial = ext - {1'b0, root_q, 2'b01};
  assign {trial_neg, trial_pad_unused, trial_rem} = trial;
  assign root_sh = {root_q, ~trial_neg};

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      rad_d  = operand_i;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = CW'(RW);
    end else if (cnt_q != '0) begin
      rad_d  = rad_q << 2;
      rem_d  = trial_neg ? ext[RW:0] : trial_rem;
      root_d = root_sh[RW-1:0];
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(1));
  assign root_o = root_q;
`ifdef ISQRT_REMAINDER_EN
  assign rem_o  = rem_q;
`endif

endmodule

// File: rtl/isqrt_arbiter.sv
// Round-robin share of one bit-serial isqrt core between two valid/ready requesters.
// Optional remainder output enabled by ISQRT_REMAINDER_EN.
module isqrt_arbiter
  import isqrt_arbiter_pkg::*;
#(
  parameter int DW = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  isqrt_arbiter_if.slave bus
);
  localparam int RW = DW / 2;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          grant_q, grant_d;
  logic          pick;
  logic          start;
  logic          core_last;
  logic [DW-1:0] operand;
  logic [RW-1:0] core_root;
  logic [1:0]    req_ready_c;
  logic [1:0]    rsp_valid_c;
`ifdef ISQRT_REMAINDER_EN
  logic [RW:0]   core_rem;
`endif

  // Preferred requester wins if it is asking, otherwise the other one.
  assign pick    = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign operand = pick ? bus.req_data1 : bus.req_data0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    start       = 1'b0;
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid != 2'b00) begin
          req_ready_c[pick] = 1'b1;
          start             = 1'b1;
          grant_d           = pick;
          ptr_d             = ~pick;
          state_d           = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid_c[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  isqrt_arbiter_core #(
    .DW(DW)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .operand_i (operand),
    .last_o    (core_last),
    .root_o    (core_root)
`ifdef ISQRT_REMAINDER_EN
    , .rem_o   (core_rem)
`endif
  );

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_root  = core_root;
`ifdef ISQRT_REMAINDER_EN
  assign bus.rsp_rem   = core_rem;
`endif
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed bench for isqrt_arbiter with a cycle-level reference model and scoreboard logs.
module tb_isqrt_arbiter;
  localparam int DW = 14;
  localparam int RW = DW / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  isqrt_arbiter_if #(.DW(DW)) bus ();
  isqrt_arbiter #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int req;
    int root;
    int rem;
    int cyc;
  } rsp_t;

  rsp_t log_q[$];
  int   gnt_q[$];
  int   gcyc_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  bit         m_busy = 1'b0;
  int         m_ptr = 0;
  int         m_grant = 0;
  int         m_t0 = 0;
  int         m_d = 0;
  int         g;
  int         rem_v;
  logic [1:0] e_rdy;
  logic [1:0] e_vld;
  rsp_t       ent;

  function automatic int isqrt(input int d);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Reference: requester pick by pointer, result valid from grant+RW+1 until consumed.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_root", bus.rsp_root, 0);
    end else begin
      g     = bus.req_valid[m_ptr] ? m_ptr : 1 - m_ptr;
      e_rdy = 2'b00;
      e_vld = 2'b00;
      if (!m_busy && bus.req_valid != 2'b00) e_rdy[g] = 1'b1;
      if (m_busy && cyc >= m_t0 + RW + 1) e_vld[m_grant] = 1'b1;
      chk("req_ready", bus.req_ready, e_rdy);
      chk("rsp_valid", bus.rsp_valid, e_vld);
      chk("busy", bus.busy, m_busy);
      rem_v = 0;
`ifdef ISQRT_REMAINDER_EN
      rem_v = int'(bus.rsp_rem);
`endif
      if (e_vld != 2'b00) begin
        chk("rsp_root", bus.rsp_root, isqrt(m_d));
`ifdef ISQRT_REMAINDER_EN
        chk("rsp_rem", rem_v, m_d - isqrt(m_d) * isqrt(m_d));
`endif
      end
      if ((bus.req_ready & bus.req_valid) != 2'b00) begin
        gnt_q.push_back(bus.req_ready[1] ? 1 : 0);
        gcyc_q.push_back(cyc);
      end
      if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
        ent.req  = bus.rsp_valid[1] ? 1 : 0;
        ent.root = int'(bus.rsp_root);
        ent.rem  = rem_v;
        ent.cyc  = cyc;
        log_q.push_back(ent);
      end
      if (!m_busy && bus.req_valid != 2'b00) begin
        m_busy  = 1'b1;
        m_grant = g;
        m_ptr   = 1 - g;
        m_t0    = cyc;
        m_d     = (g == 1) ? int'(bus.req_data1) : int'(bus.req_data0);
      end else if (m_busy && cyc >= m_t0 + RW + 1 && bus.rsp_ready[m_grant]) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int n, input string nm);
    int k;
    k = 0;
    while (gnt_q.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    chk(nm, gnt_q.size() >= n, 1);
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int k;
    k = 0;
    while (log_q.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    chk(nm, log_q.size() >= n, 1);
  endtask

  task automatic send(input int r, input int d);
    if (r == 0) bus.req_data0 = DW'(d);
    else        bus.req_data1 = DW'(d);
    bus.req_valid[r] = 1'b1;
    wait_gnt(gnt_q.size() + 1, "send_grant_timeout");
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    int lb;
    int k;
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.rsp_ready = 2'b00;

    chk("model_16383", isqrt(16383), 127);
    chk("model_143", isqrt(143), 11);
    chk("model_200", isqrt(200), 14);

    tick(3);
    chk("reset_busy", bus.busy, 0);
    chk("reset_root", bus.rsp_root, 0);
    rst_n = 1'b1;
    tick(1);

    // Zero radicand and first-result latency
    bus.rsp_ready = 2'b11;
    send(0, 0);
    wait_rsp(1, "t1_timeout");
    chk("t1_root", log_q[0].root, 0);
    chk("t1_req", log_q[0].req, 0);
    chk("t1_latency", log_q[0].cyc - gcyc_q[0], RW + 1);
`ifdef ISQRT_REMAINDER_EN
    chk("t1_rem", log_q[0].rem, 0);
`endif

    // Full-scale, perfect square, and just-below-square radicands on requester 1
    lb = log_q.size();
    send(1, 16383); wait_rsp(lb + 1, "t2a_timeout");
    send(1, 144);   wait_rsp(lb + 2, "t2b_timeout");
    send(1, 143);   wait_rsp(lb + 3, "t2c_timeout");
    chk("t2_root_16383", log_q[lb].root, 127);
    chk("t2_root_144", log_q[lb+1].root, 12);
    chk("t2_root_143", log_q[lb+2].root, 11);
    chk("t2_req", log_q[lb+2].req, 1);
`ifdef ISQRT_REMAINDER_EN
    chk("t2_rem_16383", log_q[lb].rem, 254);
    chk("t2_rem_144", log_q[lb+1].rem, 0);
    chk("t2_rem_143", log_q[lb+2].rem, 22);
`endif

    // Contention straight after reset alternates 0,1,0,1
    do_reset();
    b  = gnt_q.size();
    lb = log_q.size();
    bus.req_data0 = DW'(100);
    bus.req_data1 = DW'(49);
    bus.req_valid = 2'b11;
    wait_gnt(b + 4, "t3_grant_timeout");
    bus.req_valid = 2'b00;
    wait_rsp(lb + 4, "t3_rsp_timeout");
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant_order", gnt_q[b+i], i % 2);
      chk("t3_rsp_req", log_q[lb+i].req, i % 2);
      chk("t3_root", log_q[lb+i].root, (i % 2 == 1) ? 7 : 10);
    end

    // Lone requester back-to-back
    b  = gnt_q.size();
    lb = log_q.size();
    bus.req_data0 = DW'(1);
    bus.req_valid[0] = 1'b1;
    wait_gnt(b + 1, "t4_g1_timeout");
    bus.req_data0 = DW'(2);
    wait_gnt(b + 2, "t4_g2_timeout");
    bus.req_data0 = DW'(3);
    wait_gnt(b + 3, "t4_g3_timeout");
    bus.req_valid = 2'b00;
    wait_rsp(lb + 3, "t4_rsp_timeout");
    for (int i = 0; i < 3; i++) begin
      chk("t4_root", log_q[lb+i].root, 1);
      chk("t4_grant_req", gnt_q[b+i], 0);
`ifdef ISQRT_REMAINDER_EN
      chk("t4_rem", log_q[lb+i].rem, i);
`endif
    end
    chk("t4_spacing_a", gcyc_q[b+1] - gcyc_q[b], RW + 2);
    chk("t4_spacing_b", gcyc_q[b+2] - gcyc_q[b+1], RW + 2);

    // Held response on requester 1 while requester 0 waits and pulses its rsp_ready
    bus.rsp_ready = 2'b00;
    b  = gnt_q.size();
    lb = log_q.size();
    send(1, 200);
    k = 0;
    while (!bus.rsp_valid[1] && k < 50) begin
      tick(1);
      k++;
    end
    chk("t5_valid_seen", bus.rsp_valid[1], 1);
    bus.req_data0 = DW'(9);
    bus.req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.rsp_ready = (i % 2 == 1) ? 2'b01 : 2'b00;
      tick(1);
      chk("t5_hold_valid", bus.rsp_valid, 2);
      chk("t5_hold_busy", bus.busy, 1);
      chk("t5_hold_req_ready", bus.req_ready, 0);
      chk("t5_hold_root", bus.rsp_root, 14);
    end
    bus.rsp_ready = 2'b11;
    wait_gnt(b + 2, "t5_grant_timeout");
    bus.req_valid = 2'b00;
    wait_rsp(lb + 2, "t5_rsp_timeout");
    chk("t5_first_req", log_q[lb].req, 1);
    chk("t5_first_root", log_q[lb].root, 14);
    chk("t5_second_req", log_q[lb+1].req, 0);
    chk("t5_second_root", log_q[lb+1].root, 3);

    // Reset during the third RUN step
    send(0, 10000);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("t6_imm_rsp_valid", bus.rsp_valid, 0);
    chk("t6_imm_req_ready", bus.req_ready, 0);
    chk("t6_imm_busy", bus.busy, 0);
    chk("t6_imm_root", bus.rsp_root, 0);
    tick(2);
    rst_n = 1'b1;
    lb = log_q.size();
    tick(20);
    chk("t6_no_stale_rsp", log_q.size(), lb);
    b = gnt_q.size();
    bus.req_data0 = DW'(25);
    bus.req_data1 = DW'(36);
    bus.req_valid = 2'b11;
    wait_gnt(b + 1, "t6_grant_timeout");
    bus.req_valid = 2'b00;
    chk("t6_grant_after_reset", gnt_q[b], 0);
    wait_rsp(lb + 1, "t6_rsp_timeout");
    chk("t6_root", log_q[lb].root, 5);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
